tohost_monitor: RTL

Synthesizable multi-channel test-completion monitor for the Riscv151 ISA/regression environment. Watches up to NUM_CH `tohost` (CSR 0x51e) write streams. Declares each channel finished on its first write with bit 0 set, decodes pass/fail codes and enforces a programmable cycle timeout. Reports a single registered verdict, so FPGA builds and multi-core benches get the same pass/fail/timeout result that the simulation-only checker produces.

---
 rtl/tohost_monitor.sv | 127 ++++++++++++
 1 files changed

// File: rtl/tohost_monitor.sv
// Multi-channel tohost completion monitor: latches per-channel finish/fail status,
// the lowest-index failure, a saturating run-cycle count and an optional timeout verdict.
module tohost_monitor #(
    parameter int NUM_CH       = 1,
    parameter int XLEN         = 32,
    parameter int CNT_W        = 32,
    parameter int STOP_ON_FAIL = 0,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_W-1:0]         timeout_limit,
    input  logic [NUM_CH-1:0]        tohost_we,
    input  logic [NUM_CH*XLEN-1:0]   tohost_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     timed_out,
    output logic [NUM_CH-1:0]        fin_mask,
    output logic [NUM_CH-1:0]        fail_mask,
    output logic [CH_W-1:0]          fail_ch,
    output logic [XLEN-2:0]          fail_code,
    output logic [CNT_W-1:0]         cycles
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    limit_q;
    logic [CNT_W-1:0]    cyc_inc, cyc_d;
    logic [NUM_CH-1:0]   fin_d, fail_d;
    logic [CH_W-1:0]     ch_d;
    logic [XLEN-2:0]     code_d;
    logic                pass_d, tmo_d;
    logic                found, complete, expire;

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    always_comb begin
        state_d  = state_q;
        fin_d    = fin_mask;
        fail_d   = fail_mask;
        ch_d     = fail_ch;
        code_d   = fail_code;
        cyc_d    = cycles;
        pass_d   = pass;
        tmo_d    = timed_out;
        found    = 1'b0;
        complete = 1'b0;
        expire   = 1'b0;
        cyc_inc  = (cycles == '1) ? cycles : cycles + 1'b1;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    fin_d   = '0;
                    fail_d  = '0;
                    ch_d    = '0;
                    code_d  = '0;
                    cyc_d   = '0;
                    pass_d  = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            RUN: begin
                cyc_d = cyc_inc;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (tohost_we[i] && tohost_wdata[i*XLEN] && !fin_mask[i]) begin
                        fin_d[i]  = 1'b1;
                        fail_d[i] = |tohost_wdata[i*XLEN+1 +: XLEN-1];
                    end
                end
                // The lowest failing index only ever moves down; an already-known
                // failure keeps its latched code, a new one takes this cycle's data.
                for (int i = 0; i < NUM_CH; i++) begin
                    if (fail_d[i] && !found) begin
                        found = 1'b1;
                        if (!fail_mask[i]) begin
                            ch_d   = CH_W'(i);
                            code_d = tohost_wdata[i*XLEN+1 +: XLEN-1];
                        end
                    end
                end
                complete = (&fin_d) || ((STOP_ON_FAIL != 0) && (|fail_d));
                expire   = (limit_q != '0) && (cyc_inc == limit_q) && !complete;
                if (complete || expire) begin
                    state_d = DONE;
                    tmo_d   = expire;
                    pass_d  = (fail_d == '0) && !expire;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fin_mask  <= '0;
            fail_mask <= '0;
            fail_ch   <= '0;
            fail_code <= '0;
            cycles    <= '0;
            pass      <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            state_q   <= state_d;
            fin_mask  <= fin_d;
            fail_mask <= fail_d;
            fail_ch   <= ch_d;
            fail_code <= code_d;
            cycles    <= cyc_d;
            pass      <= pass_d;
            timed_out <= tmo_d;
        end
    end

    // Budget is only consulted in RUN, which is always entered through this load.
    always_ff @(posedge clk) begin
        if (start && (state_q != RUN))
            limit_q <= timeout_limit;
    end

endmodule
